gp_regfile_bank: RTL and testbench

Parametrised general-purpose register bank replacing the per-register instances in the datapath. Holds `NREGS` registers of `WIDTH` bits behind a one-cycle write-back staging register. Provides two combinational read ports with R0 zero-forcing under `BAout`, and a per-register busy scoreboard that the control unit uses to hold off reads of registers with a pending write.

---
 rtl/gp_regfile_bank.sv | 156 +++++++++++++++
 tb/tb_gp_regfile_bank.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gp_regfile_bank.sv
// ----------------------------------------------------------------------------
// gp_regfile_bank
//
// General-purpose register bank: NREGS registers of WIDTH bits, written
// through a one-cycle staging register and read through two combinational
// ports. A busy scoreboard (one bit per register) lets the control unit hold
// off reads of registers that have a reservation outstanding.
//
// Build option:
//   GP_REGFILE_BYPASS_EN  when defined, a read port whose select matches the
//                         valid stage returns the staged data, and that
//                         port's busy output reads 0. When undefined, reads
//                         see committed storage only.
//
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-low clear
//   BAout      forces any read port selecting R0 to return zero
//   rd_sel_a   read port A select       rd_data_a  read port A data
//   rd_sel_b   read port B select       rd_data_b  read port B data
//   busy_a     port A register reserved busy_b    port B register reserved
//   wr_en      write request            wr_sel     write register select
//   BusMuxOut  write data
//   resv_en    reserve request          resv_sel   register to reserve
//   resv_err   sticky: reservation of an already-busy register
// ----------------------------------------------------------------------------
module gp_regfile_bank #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             BAout,
    input  logic [AW-1:0]    rd_sel_a,
    input  logic [AW-1:0]    rd_sel_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_sel,
    input  logic [WIDTH-1:0] BusMuxOut,
    input  logic             resv_en,
    input  logic [AW-1:0]    resv_sel,
    output logic             resv_err
);

    // Elaboration-time sanity check of the geometry.
    if (NREGS < 2 || (2 ** AW) != NREGS) begin : g_bad_geometry
        $error("gp_regfile_bank: NREGS must be a power of two >= 2 and equal 2**AW");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_stg_vld;
    logic [AW-1:0]    r_stg_sel;
    logic [WIDTH-1:0] r_stg_data;
    logic [NREGS-1:0] r_busy;
    logic             r_resv_err;

    logic [NREGS-1:0] w_busy_nxt;
    logic             w_resv_clash;
    logic             w_stg_hit_a;
    logic             w_stg_hit_b;
    logic [WIDTH-1:0] w_raw_a;
    logic [WIDTH-1:0] w_raw_b;

    // ------------------------------------------------------------------
    // Scoreboard next state. The commit clear is applied first so that a
    // reservation landing on the committing register wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_stg_vld) begin
            w_busy_nxt[r_stg_sel] = 1'b0;
        end
        if (resv_en) begin
            w_busy_nxt[resv_sel] = 1'b1;
        end
    end

    // The error looks at the busy bit as it stands before this edge.
    assign w_resv_clash = resv_en & r_busy[resv_sel];

    // ------------------------------------------------------------------
    // Sequential state: storage, stage, scoreboard, sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
            r_stg_vld  <= 1'b0;
            r_stg_sel  <= '0;
            r_stg_data <= '0;
            r_busy     <= '0;
            r_resv_err <= 1'b0;
        end else begin
            // Commit whatever was staged at the previous edge.
            if (r_stg_vld) begin
                r_regs[r_stg_sel] <= r_stg_data;
            end

            r_stg_vld <= wr_en;
            if (wr_en) begin
                r_stg_sel  <= wr_sel;
                r_stg_data <= BusMuxOut;
            end

            r_busy <= w_busy_nxt;

            if (w_resv_clash) begin
                r_resv_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
`ifdef GP_REGFILE_BYPASS_EN
    assign w_stg_hit_a = r_stg_vld && (r_stg_sel == rd_sel_a);
    assign w_stg_hit_b = r_stg_vld && (r_stg_sel == rd_sel_b);
`else
    assign w_stg_hit_a = 1'b0;
    assign w_stg_hit_b = 1'b0;
`endif

    assign w_raw_a = w_stg_hit_a ? r_stg_data : r_regs[rd_sel_a];
    assign w_raw_b = w_stg_hit_b ? r_stg_data : r_regs[rd_sel_b];

    // R0 zeroing masks only the output; the stored value is untouched.
    always_comb begin
        rd_data_a = w_raw_a;
        if (BAout && (rd_sel_a == '0)) begin
            rd_data_a = '0;
        end
    end

    always_comb begin
        rd_data_b = w_raw_b;
        if (BAout && (rd_sel_b == '0)) begin
            rd_data_b = '0;
        end
    end

    // A forwarded register is no longer pending from the reader's view.
    assign busy_a = r_busy[rd_sel_a] & ~w_stg_hit_a;
    assign busy_b = r_busy[rd_sel_b] & ~w_stg_hit_b;

    assign resv_err = r_resv_err;

endmodule

// File: tb/tb_gp_regfile_bank.sv
module tb_gp_regfile_bank;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREGS = 16;
    localparam int unsigned AW    = 4;
`ifdef GP_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             clr;
    logic             BAout;
    logic [AW-1:0]    rd_sel_a, rd_sel_b;
    logic [WIDTH-1:0] rd_data_a, rd_data_b;
    logic             busy_a, busy_b;
    logic             wr_en;
    logic [AW-1:0]    wr_sel;
    logic [WIDTH-1:0] BusMuxOut;
    logic             resv_en;
    logic [AW-1:0]    resv_sel;
    logic             resv_err;

    gp_regfile_bank #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
        .clk       (clk),
        .clr       (clr),
        .BAout     (BAout),
        .rd_sel_a  (rd_sel_a),
        .rd_sel_b  (rd_sel_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .BusMuxOut (BusMuxOut),
        .resv_en   (resv_en),
        .resv_sel  (resv_sel),
        .resv_err  (resv_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: committed contents, one pending write, reservations.
    logic [WIDTH-1:0] m_regs [NREGS];
    bit               m_busy [NREGS];
    bit               m_pend_vld;
    int unsigned      m_pend_sel;
    logic [WIDTH-1:0] m_pend_data;
    bit               m_err;

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Apply the rules of one rising edge to the model using current inputs.
    task automatic model_edge();
        bit was_busy [NREGS];
        if (!clr) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_pend_vld = 1'b0;
            m_err      = 1'b0;
            return;
        end
        was_busy = m_busy;
        if (m_pend_vld) begin
            m_regs[m_pend_sel] = m_pend_data;
            m_busy[m_pend_sel] = 1'b0;
        end
        if (resv_en) begin
            if (was_busy[resv_sel]) m_err = 1'b1;
            m_busy[resv_sel] = 1'b1;
        end
        m_pend_vld  = wr_en;
        m_pend_sel  = int'(wr_sel);
        m_pend_data = BusMuxOut;
    endtask

    function automatic logic [WIDTH-1:0] exp_rd(input int unsigned sel);
        logic [WIDTH-1:0] v;
        v = m_regs[sel];
        if (BYP && m_pend_vld && m_pend_sel == sel) v = m_pend_data;
        if (sel == 0 && BAout) v = '0;
        return v;
    endfunction

    function automatic logic exp_busy(input int unsigned sel);
        return m_busy[sel] && !(BYP && m_pend_vld && m_pend_sel == sel);
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        #1;
        chk({tag, " rd_data_a"}, rd_data_a, exp_rd(rd_sel_a));
        chk({tag, " rd_data_b"}, rd_data_b, exp_rd(rd_sel_b));
        chk({tag, " busy_a"}, {31'b0, busy_a}, {31'b0, exp_busy(rd_sel_a)});
        chk({tag, " busy_b"}, {31'b0, busy_b}, {31'b0, exp_busy(rd_sel_b)});
        chk({tag, " resv_err"}, {31'b0, resv_err}, {31'b0, m_err});
    endtask

    typedef struct {
        logic             wr_en;
        logic [AW-1:0]    wr_sel;
        logic [WIDTH-1:0] data;
        logic             ba;
        logic [AW-1:0]    sa;
        logic [AW-1:0]    sb;
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // Rows: inputs applied, outputs checked before the edge, then edge.
        // Busy and resv_err are expected 0 throughout this table.
        vecs[0]  = '{1'b1, 4'd0, 32'h1234_5678, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0,
                     BYP ? 32'h1234_5678 : 32'h0, BYP ? 32'h1234_5678 : 32'h0};
        vecs[2]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 32'h1234_5678, 32'h1234_5678};
        vecs[3]  = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 4'd0, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 32'h1234_5678, 32'h1234_5678};
        vecs[5]  = '{1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1, 4'd3, 4'd0, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 4'd0,
                     BYP ? 32'hDEAD_BEEF : 32'h0, 32'h0};
        vecs[7]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 4'd0, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[8]  = '{1'b1, 4'd1, 32'hA, 1'b0, 4'd1, 4'd2, 32'h0, 32'h0};
        vecs[9]  = '{1'b1, 4'd1, 32'hB, 1'b0, 4'd1, 4'd2, BYP ? 32'hA : 32'h0, 32'h0};
        vecs[10] = '{1'b1, 4'd2, 32'hC, 1'b0, 4'd1, 4'd2, BYP ? 32'hB : 32'hA, 32'h0};
        vecs[11] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd1, 4'd2, 32'hB, BYP ? 32'hC : 32'h0};
        vecs[12] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd1, 4'd2, 32'hB, 32'hC};

        for (int i = 0; i < int'(NREGS); i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_pend_vld = 1'b0; m_pend_sel = 0; m_pend_data = '0; m_err = 1'b0;

        // ---------------- Reset with a write request held ---------------
        clr = 1'b0; BAout = 1'b0; rd_sel_a = '0; rd_sel_b = '0;
        wr_en = 1'b1; wr_sel = 4'd5; BusMuxOut = 32'hFFFF_FFFF;
        resv_en = 1'b1; resv_sel = 4'd5;
        tick();
        tick();
        clr = 1'b1; wr_en = 1'b0; resv_en = 1'b0;
        for (int s = 0; s < int'(NREGS); s++) begin
            rd_sel_a = AW'(s); rd_sel_b = AW'(NREGS - 1 - s);
            #1;
            chk("reset rd_data_a", rd_data_a, 32'h0);
            chk("reset busy_a", {31'b0, busy_a}, 32'h0);
            chk("reset busy_b", {31'b0, busy_b}, 32'h0);
        end
        chk("reset resv_err", {31'b0, resv_err}, 32'h0);
        tick();
        rd_sel_a = 4'd5;
        #1;
        chk("reset discards staged write", rd_data_a, 32'h0);

        // ---------------- Table: R0 zeroing, latency, back-to-back -----
        for (int i = 0; i < 13; i++) begin
            wr_en = vecs[i].wr_en; wr_sel = vecs[i].wr_sel; BusMuxOut = vecs[i].data;
            BAout = vecs[i].ba; rd_sel_a = vecs[i].sa; rd_sel_b = vecs[i].sb;
            #1;
            chk($sformatf("vec%0d rd_data_a", i), rd_data_a, vecs[i].ea);
            chk($sformatf("vec%0d rd_data_b", i), rd_data_b, vecs[i].eb);
            chk($sformatf("vec%0d busy", i), {30'b0, busy_a, busy_b}, 32'h0);
            chk($sformatf("vec%0d resv_err", i), {31'b0, resv_err}, 32'h0);
            tick();
        end
        wr_en = 1'b0; BAout = 1'b0;

        // ---------------- Scoreboard: reserve R7, then write it ----------
        rd_sel_a = 4'd7; rd_sel_b = 4'd7; resv_en = 1'b1; resv_sel = 4'd7;
        #1;
        chk("sb busy before resv", {31'b0, busy_a}, 32'h0);
        tick();                                   // edge 1
        resv_en = 1'b0;
        #1;
        chk("sb busy after resv", {31'b0, busy_a}, 32'h1);
        tick(); tick();                           // edges 2, 3
        wr_en = 1'b1; wr_sel = 4'd7; BusMuxOut = 32'h77;
        #1;
        chk("sb busy held", {31'b0, busy_b}, 32'h1);
        tick();                                   // edge 4
        wr_en = 1'b0;
        #1;
        chk("sb busy after stage", {31'b0, busy_a}, BYP ? 32'h0 : 32'h1);
        chk("sb data after stage", rd_data_a, BYP ? 32'h77 : 32'h0);
        tick();                                   // edge 5
        chk("sb busy after commit", {31'b0, busy_a}, 32'h0);
        chk("sb data after commit", rd_data_a, 32'h77);
        chk("sb resv_err", {31'b0, resv_err}, 32'h0);

        // ---------------- Collision on R2 and sticky error ---------------
        rd_sel_a = 4'd2; wr_en = 1'b1; wr_sel = 4'd2; BusMuxOut = 32'h22;
        tick();
        wr_en = 1'b0; resv_en = 1'b1; resv_sel = 4'd2;
        tick();                                   // commit and reserve together
        resv_en = 1'b0;
        #1;
        chk("col busy kept", {31'b0, busy_a}, 32'h1);
        chk("col data", rd_data_a, 32'h22);
        chk("col no err", {31'b0, resv_err}, 32'h0);
        tick();
        chk("col busy stays", {31'b0, busy_a}, 32'h1);
        resv_en = 1'b1;
        tick();
        resv_en = 1'b0;
        chk("col err set", {31'b0, resv_err}, 32'h1);
        chk("col busy after err", {31'b0, busy_a}, 32'h1);
        tick(); tick(); tick();
        chk("col err sticky", {31'b0, resv_err}, 32'h1);
        clr = 1'b0;
        tick();
        clr = 1'b1;
        #1;
        chk("col err cleared", {31'b0, resv_err}, 32'h0);
        chk("col busy cleared", {31'b0, busy_a}, 32'h0);

        // ---------------- Randomized against the model -------------------
        for (int c = 0; c < 3000; c++) begin
            clr       = ($urandom_range(0, 59) != 0);
            BAout     = $urandom_range(0, 1) == 1;
            wr_en     = $urandom_range(0, 2) != 0;
            wr_sel    = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            BusMuxOut = $urandom;
            resv_en   = $urandom_range(0, 5) == 0;
            resv_sel  = AW'($urandom_range(0, 3));
            rd_sel_a  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            rd_sel_b  = AW'($urandom_range(0, 3));
            // Keep clear of re-reserving a busy register on its own commit edge.
            if (resv_en && m_busy[resv_sel] && m_pend_vld && m_pend_sel == int'(resv_sel))
                resv_en = 1'b0;
            check_model("rand");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
